seed_random_2_data_path_counter: RTL and testbench

//  Pseudo-random card source for the blackjack datapath.
//  A free-running deck-index counter (0..51) advances every clock, so the request timing from
//  the player/dealer FSM supplies the randomness.
//  On each new card request, the current index is snapshotted and presented as an encoded card
//  (suit + rank) on next_card_o.

---
 rtl/seed_random_2_data_path_counter.sv | 42 ++++
 tb/tb_seed_random_2_data_path_counter.sv | 116 +++++++++++
 2 files changed

// File: rtl/seed_random_2_data_path_counter.sv
// seed_random_2_data_path_counter: free-running deck index snapshotted into an encoded card
// on each rising edge of the card request.
module seed_random_2_data_path_counter #(
  parameter int DECK_SIZE = 52,
  parameter int RANKS     = 13
) (
  input  logic       clk_dp_c_i,
  input  logic       rst_dp_c_i,
  input  logic       req_card_state_dp_c_i,
  output logic [7:0] next_card_o
);
  logic [5:0] r_count;
  logic       r_req;
  logic [7:0] r_card;
  logic       w_take;
  logic [1:0] w_suit;
  logic [5:0] w_off;
  logic [3:0] w_rank;
  // Division by RANKS as a compare/subtract chain over the four suits
  always_comb begin
    w_suit = (r_count >= 6'(3*RANKS)) ? 2'd3 :
             (r_count >= 6'(2*RANKS)) ? 2'd2 :
             (r_count >= 6'(RANKS))   ? 2'd1 : 2'd0;
    w_off  = (r_count >= 6'(3*RANKS)) ? 6'(3*RANKS) :
             (r_count >= 6'(2*RANKS)) ? 6'(2*RANKS) :
             (r_count >= 6'(RANKS))   ? 6'(RANKS)   : 6'd0;
    w_rank = 4'(r_count - w_off + 6'd1);
    w_take = req_card_state_dp_c_i & ~r_req;
  end
  always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
    if (!rst_dp_c_i) begin
      r_count <= '0;
      r_req   <= 1'b0;
      r_card  <= 8'h00;
    end else begin
      r_count <= (r_count == 6'(DECK_SIZE-1)) ? 6'd0 : r_count + 6'd1;
      r_req   <= req_card_state_dp_c_i;
      r_card  <= w_take ? {2'b00, w_suit, w_rank} : r_card;
    end
  end
  assign next_card_o = r_card;
endmodule

// File: tb/tb_seed_random_2_data_path_counter.sv
// tb_seed_random_2_data_path_counter: directed scenarios plus randomized requests and resets,
// checked against a deck-position model using plain division and modulo.
module tb_seed_random_2_data_path_counter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] card;
  int         n_checks = 0;
  int         n_errors = 0;
  int         m_idx = 0;
  logic       m_prev = 1'b0;
  logic [7:0] m_card = 8'h00;

  seed_random_2_data_path_counter dut (
    .clk_dp_c_i           (clk),
    .rst_dp_c_i           (rst_n),
    .req_card_state_dp_c_i(req),
    .next_card_o          (card)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input int i);
    return {2'b00, 2'(i / 13), 4'(i % 13 + 1)};
  endfunction

  // Reference: deck position counts clock edges since reset, a card is dealt on a fresh request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx  <= 0;
      m_prev <= 1'b0;
      m_card <= 8'h00;
    end else begin
      if (req && !m_prev) m_card <= enc(m_idx);
      m_prev <= req;
      m_idx  <= (m_idx + 1) % 52;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("card_model", card, m_card);
    check("count_model", {2'b00, dut.r_count}, 8'(m_idx));
  endtask

  task automatic draw_at(input int target, input logic [7:0] exp, input string tag);
    int guard = 0;
    req = 1'b0;
    tick();
    while (m_idx != target && guard < 60) begin
      tick();
      guard++;
    end
    check({tag, "_reach"}, 8'(m_idx), 8'(target));
    req = 1'b1;
    tick();
    check(tag, card, exp);
  endtask

  initial begin
    #1;
    check("reset_card", card, 8'h00);
    check("reset_count", {2'b00, dut.r_count}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    req = 1'b1;
    tick();
    check("first_draw", card, 8'h02);
    repeat (4) tick();
    req = 1'b0;
    check("hold_high", card, 8'h02);
    repeat (5) tick();
    check("hold_low", card, 8'h02);
    req = 1'b1;
    tick();
    check("second_draw", card, 8'h0C);
    draw_at(51, 8'h3D, "draw_51");
    check("wrap_count", {2'b00, dut.r_count}, 8'h00);
    draw_at(13, 8'h11, "draw_13");
    draw_at(0, 8'h01, "draw_0");
    draw_at(12, 8'h0D, "draw_12");
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_card", card, 8'h00);
    check("async_reset_count", {2'b00, dut.r_count}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("draw_after_reset", card, 8'h01);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #3;
        rst_n = 1'b0;
        #1;
        check("rand_reset", card, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) req = 1'(($urandom_range(0, 1)));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
